// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor (CLINT).
// Contents:
//   - register offsets inside the 64 KiB CLINT window
//   - bus FSM state type
//   - apply_byte_en: merges new write data into an old 32-bit word per byte lane
package clint_pkg;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;  // msip[h] at +4h
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;  // mtimecmp[h] at +8h (lo), +8h+4 (hi)
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;  // mtime lo, hi at +4

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } clint_state_t;

  function automatic logic [31:0] apply_byte_en(
    input logic [31:0] old_val,
    input logic [31:0] new_val,
    input logic [3:0]  be
  );
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_mtime_counter.sv
// Free-running 64-bit machine timer with prescaler.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   wr_lo, wr_hi    commit a bus write to the low / high mtime word this cycle
//   wdata, byte_en  write data and byte lane enables for that write
//   mtime           current machine time
module clint_mtime_counter
  import clint_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  output logic [63:0] mtime
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] r_presc;
  logic [63:0]   r_mtime;
  logic          w_tick;

  assign w_tick = (r_presc == PW'(PRESCALE - 1));
  assign mtime  = r_mtime;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_presc <= '0;
      r_mtime <= '0;
    end else begin
      // The prescaler keeps running even when software writes mtime.
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      // A software write wins over a coincident tick; the tick is lost and
      // the half not being written keeps its value.
      if (wr_lo || wr_hi) begin
        if (wr_lo) r_mtime[31:0]  <= apply_byte_en(r_mtime[31:0], wdata, byte_en);
        if (wr_hi) r_mtime[63:32] <= apply_byte_en(r_mtime[63:32], wdata, byte_en);
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end
    end
  end

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: memory-mapped mtime / mtimecmp / msip with per-hart
// machine timer and software interrupt outputs.
// Ports:
//   CLK, RST                          clock, synchronous active-high reset
//   addr, wdata, byte_en, ren, wen    generic-bus slave request
//   rdata, busy                       response; busy drops for one cycle per request
//   mtime                             current machine time
//   timer_int, soft_int               per-hart MTIP / MSIP
module clint_timer
  import clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          NUM_HARTS = 2,
  parameter int          PRESCALE  = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic [3:0]           byte_en,
  input  logic                 ren,
  input  logic                 wen,
  output logic [31:0]          rdata,
  output logic                 busy,
  output logic [63:0]          mtime,
  output logic [NUM_HARTS-1:0] timer_int,
  output logic [NUM_HARTS-1:0] soft_int
);

  clint_state_t         r_state;
  logic [15:0]          r_off;
  logic [31:0]          r_wdata;
  logic [3:0]           r_be;
  logic                 r_is_wr;
  logic [31:0]          r_rdata;
  logic                 r_busy;
  logic [63:0]          r_mtimecmp [NUM_HARTS];
  logic [NUM_HARTS-1:0] r_msip;
  logic [NUM_HARTS-1:0] r_timer_int;
  logic [NUM_HARTS-1:0] r_soft_int;

  logic [63:0]          w_mtime;
  logic                 w_req;
  logic                 w_commit;
  logic [15:0]          w_rd_off;
  logic [15:0]          w_wr_off;
  logic [31:0]          w_rd_val;
  logic                 w_wr_mtime_lo;
  logic                 w_wr_mtime_hi;
  logic [NUM_HARTS-1:0] w_wr_msip;
  logic [NUM_HARTS-1:0] w_wr_cmp_lo;
  logic [NUM_HARTS-1:0] w_wr_cmp_hi;

  assign w_req    = (ren || wen) && (addr[31:16] == BASE_ADDR[31:16]);
  // Writes land on the edge that leaves RESP; an all-zero byte mask is a no-op.
  assign w_commit = (r_state == RESP) && r_is_wr && (r_be != 4'b0000);
  assign w_rd_off = addr[15:0] & 16'hFFFC;
  assign w_wr_off = r_off & 16'hFFFC;

  assign w_wr_mtime_lo = w_commit && (w_wr_off == MTIME_OFF);
  assign w_wr_mtime_hi = w_commit && (w_wr_off == MTIME_OFF + 16'd4);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_HARTS; gi++) begin : g_wr_dec
      assign w_wr_msip[gi]   = w_commit && (w_wr_off == MSIP_OFF + 16'(4 * gi));
      assign w_wr_cmp_lo[gi] = w_commit && (w_wr_off == MTIMECMP_OFF + 16'(8 * gi));
      assign w_wr_cmp_hi[gi] = w_commit && (w_wr_off == MTIMECMP_OFF + 16'(8 * gi + 4));
    end
  endgenerate

  clint_mtime_counter #(
    .PRESCALE(PRESCALE)
  ) u_mtime (
    .CLK    (CLK),
    .RST    (RST),
    .wr_lo  (w_wr_mtime_lo),
    .wr_hi  (w_wr_mtime_hi),
    .wdata  (r_wdata),
    .byte_en(r_be),
    .mtime  (w_mtime)
  );

  // Read mux on the incoming address; anything not matched reads as zero.
  always_comb begin
    w_rd_val = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (w_rd_off == MSIP_OFF + 16'(4 * h))         w_rd_val = {31'd0, r_msip[h]};
      if (w_rd_off == MTIMECMP_OFF + 16'(8 * h))     w_rd_val = r_mtimecmp[h][31:0];
      if (w_rd_off == MTIMECMP_OFF + 16'(8 * h + 4)) w_rd_val = r_mtimecmp[h][63:32];
    end
    if (w_rd_off == MTIME_OFF)         w_rd_val = w_mtime[31:0];
    if (w_rd_off == MTIME_OFF + 16'd4) w_rd_val = w_mtime[63:32];
  end

  // Bus FSM: read data is captured on acceptance so it is stable in RESP.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_busy  <= 1'b1;
      r_rdata <= '0;
      r_off   <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_is_wr <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state <= RESP;
            r_busy  <= 1'b0;
            r_rdata <= wen ? 32'd0 : w_rd_val;
            r_off   <= addr[15:0];
            r_wdata <= wdata;
            r_be    <= byte_en;
            r_is_wr <= wen;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_busy  <= 1'b1;
          r_rdata <= '0;
          r_is_wr <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // Per-hart compare and software-interrupt registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int h = 0; h < NUM_HARTS; h++) r_mtimecmp[h] <= '1;
      r_msip      <= '0;
      r_timer_int <= '0;
      r_soft_int  <= '0;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (w_wr_cmp_lo[h])
          r_mtimecmp[h][31:0] <= apply_byte_en(r_mtimecmp[h][31:0], r_wdata, r_be);
        if (w_wr_cmp_hi[h])
          r_mtimecmp[h][63:32] <= apply_byte_en(r_mtimecmp[h][63:32], r_wdata, r_be);
        if (w_wr_msip[h] && r_be[0])
          r_msip[h] <= r_wdata[0];
        r_timer_int[h] <= (w_mtime >= r_mtimecmp[h]);
      end
      r_soft_int <= r_msip;
    end
  end

  assign rdata     = r_rdata;
  assign busy      = r_busy;
  assign mtime     = w_mtime;
  assign timer_int = r_timer_int;
  assign soft_int  = r_soft_int;

endmodule

// File: tb/tb_clint_timer.sv
module tb_clint_timer;

  localparam logic [31:0] B = 32'h0200_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  byte_en = '0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [31:0] rdata;
  logic        busy;
  logic [63:0] mtime;
  logic [1:0]  timer_int;
  logic [1:0]  soft_int;

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;

  clint_timer #(
    .BASE_ADDR(B),
    .NUM_HARTS(2),
    .PRESCALE (1)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .addr     (addr),
    .wdata    (wdata),
    .byte_en  (byte_en),
    .ren      (ren),
    .wen      (wen),
    .rdata    (rdata),
    .busy     (busy),
    .mtime    (mtime),
    .timer_int(timer_int),
    .soft_int (soft_int)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  // Issues one request, waits (bounded) for busy low, then drops the request
  // one step after the completing edge. lat counts edges until busy was low.
  task automatic bus(input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be,
                     output logic [31:0] rd, output int lat);
    addr = a; wdata = d; byte_en = be; ren = r; wen = w; lat = 0;
    do begin
      @(posedge CLK); #1; lat++;
    end while (busy && lat < 20);
    rd = rdata;
    ren = 1'b0; wen = 1'b0;
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic [1:0]  exp_soft;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [31:0] rd;
    int          lat;
    int          n;
    int          t1;
    int          t2;

    vecs[0]  = '{1'b1, 1'b0, B + 32'h0000, 32'h0,        4'hF, 32'h0,        2'b00}; // rd msip0
    vecs[1]  = '{1'b0, 1'b1, B + 32'h0004, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b10}; // wr msip1
    vecs[2]  = '{1'b1, 1'b0, B + 32'h0004, 32'h0,        4'hF, 32'h1,        2'b10}; // rd msip1
    vecs[3]  = '{1'b1, 1'b0, B + 32'h0008, 32'h0,        4'hF, 32'h0,        2'b10}; // msip2 absent
    vecs[4]  = '{1'b0, 1'b1, B + 32'h0000, 32'h1,        4'hE, 32'h0,        2'b10}; // lane0 off
    vecs[5]  = '{1'b1, 1'b0, B + 32'h0000, 32'h0,        4'hF, 32'h0,        2'b10};
    vecs[6]  = '{1'b0, 1'b1, B + 32'h0004, 32'h0,        4'hF, 32'h0,        2'b00}; // clr msip1
    vecs[7]  = '{1'b1, 1'b0, B + 32'h0004, 32'h0,        4'hF, 32'h0,        2'b00};
    vecs[8]  = '{1'b0, 1'b1, B + 32'h4008, 32'h12345678, 4'h3, 32'h0,        2'b00}; // cmp1 lo
    vecs[9]  = '{1'b1, 1'b0, B + 32'h4008, 32'h0,        4'hF, 32'hFFFF5678, 2'b00};
    vecs[10] = '{1'b0, 1'b1, B + 32'h400C, 32'h0,        4'h0, 32'h0,        2'b00}; // be=0
    vecs[11] = '{1'b1, 1'b0, B + 32'h400C, 32'h0,        4'hF, 32'hFFFFFFFF, 2'b00};
    vecs[12] = '{1'b1, 1'b0, B + 32'h4000, 32'h0,        4'hF, 32'h00000020, 2'b00}; // cmp0 lo
    vecs[13] = '{1'b1, 1'b1, B + 32'h0000, 32'h1,        4'hF, 32'h0,        2'b01}; // rd+wr
    vecs[14] = '{1'b1, 1'b0, B + 32'h0000, 32'h0,        4'hF, 32'h1,        2'b01};
    vecs[15] = '{1'b0, 1'b1, B + 32'h0000, 32'h0,        4'hF, 32'h0,        2'b00};

    // ---- reset state, then 10 idle cycles ----
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_rdata", rdata, 0);
    chk("rst_mtime", mtime, 0);
    chk("rst_mtip", timer_int, 0);
    chk("rst_msip", soft_int, 0);
    RST = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    chk("idle10_mtime", mtime, 64'd10);
    chk("idle10_mtip", timer_int, 0);
    chk("idle10_msip", soft_int, 0);
    chk("idle10_busy", busy, 1);

    // ---- timer compare ----
    bus(1'b0, 1'b1, B + 32'h4000, 32'h20, 4'hF, rd, lat);
    chk("cmp0_lo_lat", lat, 1);
    bus(1'b0, 1'b1, B + 32'h4004, 32'h0, 4'hF, rd, lat);
    n = 0;
    while (mtime != 64'h20 && n < 100) begin
      @(posedge CLK); #1; n++;
    end
    chk("mtime_reach_20", mtime, 64'h20);
    chk("mtip0_before", timer_int[0], 0);
    @(posedge CLK); #1;
    chk("mtip0_rise", timer_int[0], 1);
    chk("mtip1_quiet", timer_int[1], 0);
    bus(1'b0, 1'b1, B + 32'h4004, 32'h1, 4'hF, rd, lat);
    @(posedge CLK); #1;
    chk("mtip0_at_commit", timer_int[0], 1);
    @(posedge CLK); #1;
    chk("mtip0_fall", timer_int[0], 0);

    // ---- register table ----
    for (int i = 0; i < 16; i++) begin
      bus(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].be, rd, lat);
      chk($sformatf("vec%0d_lat", i), lat, 1);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      @(posedge CLK); #1;
      chk($sformatf("vec%0d_busy_once", i), busy, 1);
      @(posedge CLK); #1;
      chk($sformatf("vec%0d_msip", i), soft_int, vecs[i].exp_soft);
    end

    // ---- mtime write priority and wrap ----
    bus(1'b0, 1'b1, B + 32'hBFF8, 32'hFFFFFFFF, 4'b0011, rd, lat);
    @(posedge CLK); #1;
    chk("mtime_partial_wr", mtime, 64'h0000_0000_0000_FFFF);
    @(posedge CLK); #1;
    chk("mtime_resume", mtime, 64'h0000_0000_0001_0000);
    bus(1'b0, 1'b1, B + 32'hBFFC, 32'hFFFFFFFF, 4'hF, rd, lat);
    bus(1'b0, 1'b1, B + 32'hBFF8, 32'hFFFFFFFF, 4'hF, rd, lat);
    chk("mtime_hi_wr", mtime[63:32], 32'hFFFFFFFF);
    @(posedge CLK); #1;
    chk("mtime_all_ones", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge CLK); #1;
    chk("mtime_wrap", mtime, 64'h0);

    // ---- out-of-window request is ignored ----
    addr = 32'h0300_0000; ren = 1'b1; byte_en = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk($sformatf("oow_busy%0d", i), busy, 1);
    end
    ren = 1'b0;
    @(posedge CLK); #1;

    // ---- unmapped reads, back to back ----
    bus(1'b1, 1'b0, B + 32'h4028, 32'h0, 4'hF, rd, lat);
    t1 = cyc_cnt;
    chk("cmp5_rdata", rd, 0);
    chk("cmp5_lat", lat, 1);
    bus(1'b1, 1'b0, B + 32'h8000, 32'h0, 4'hF, rd, lat);
    t2 = cyc_cnt;
    chk("off8000_rdata", rd, 0);
    chk("b2b_spacing", t2 - t1, 2);
    @(posedge CLK); #1;
    chk("b2b_busy_once", busy, 1);

    // ---- reset during RESP of a mtimecmp write ----
    bus(1'b0, 1'b1, B + 32'h400C, 32'h0, 4'hF, rd, lat);
    chk("midrst_in_resp", busy, 0);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("midrst_busy", busy, 1);
    chk("midrst_mtime", mtime, 0);
    chk("midrst_msip", soft_int, 0);
    @(posedge CLK); #1;
    chk("midrst_busy_next", busy, 1);
    chk("midrst_mtime_next", mtime, 1);
    bus(1'b1, 1'b0, B + 32'h400C, 32'h0, 4'hF, rd, lat);
    chk("midrst_cmp1_hi", rd, 32'hFFFFFFFF);
    chk("midrst_rd_lat", lat, 1);
    bus(1'b1, 1'b0, B + 32'h4008, 32'h0, 4'hF, rd, lat);
    chk("midrst_cmp1_lo", rd, 32'hFFFFFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Core-local interruptor (CLINT) that sits directly upstream of the core top level.
- Produces the free-running 64-bit mtime that each hart's privilege unit consumes.
- Drives the per-hart machine timer and software interrupt lines into core_interrupt_if.
- Memory-mapped through a generic-bus slave port, so software reads and writes mtime, mtimecmp and msip with ordinary loads and stores.

Parameters:
- BASE_ADDR, 32'h0200_0000, base of the 64 KiB CLINT window.
- NUM_HARTS, 2, number of harts served (1..16).
- PRESCALE, 1, CLK cycles per mtime tick (1..65535).

Ports:
- CLK  input  1  core clock.
- RST  input  1  synchronous active-high reset.
- addr  input  32  bus address (word aligned).
- wdata  input  32  write data.
- byte_en  input  4  byte lane enables.
- ren  input  1  read request.
- wen  input  1  write request.
- rdata  output  32  read data, valid when busy==0.
- busy  output  1  low for exactly one cycle to complete a request.
- mtime  output  64  current machine time.
- timer_int  output  NUM_HARTS  per-hart MTIP.
- soft_int  output  NUM_HARTS  per-hart MSIP.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (ports CLK, RST).
- Values on RST=1: mtime=0, prescale count=0, every mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, timer_int=0, soft_int=0, busy=1, rdata=0, FSM=IDLE.
- Register map, offsets from BASE_ADDR:
  - msip[h] at 0x0000+4h; only bit0 is writable, other bits read 0.
  - mtimecmp[h] low word at 0x4000+8h, high word at 0x4004+8h.
  - mtime low word at 0xBFF8, high word at 0xBFFC.
- Address decode: a request is in the window when addr[31:16]==BASE_ADDR[31:16]. Unmapped offsets, or harts >= NUM_HARTS, read 0 and ignore writes. busy still completes normally for these.
- Bus FSM:
  - IDLE: busy=1. When (ren|wen) is seen in the window, latch the request and go to RESP.
  - RESP: busy=0 and rdata is driven from the latched address; the write commits on the clock edge leaving RESP. Always return to IDLE.
  - Latency: 1 cycle from request to busy low. The master holds its request until busy is low. A back-to-back request is accepted on the IDLE cycle that follows.
  - ren and wen asserted together are treated as a write; rdata=0.
  - Requests outside the window are ignored: no state change, busy stays 1.
- Byte enables: applied per lane to all writable registers. byte_en=0 is a no-op write that still completes.
- mtime counting:
  - The prescale counter counts 0..PRESCALE-1. On the wrap, mtime <= mtime+1 (64-bit, wraps to 0 after all-ones).
  - PRESCALE=1 increments every cycle.
- Write to mtime: a write to either mtime half in the same cycle as a tick takes priority. The written half is stored, the unwritten half is held unchanged, and that tick is dropped. The prescale counter is not reset.
- Comparison: timer_int[h] is registered as (mtime >= mtimecmp[h]), unsigned 64-bit, evaluated on the current register values. It asserts exactly one cycle after the condition first holds and deasserts one cycle after a mtimecmp write makes it false.
- soft_int[h] equals msip[h] bit0, registered; it changes the cycle after the commit edge.
- Reset mid-transaction: the pending request is dropped with no write, and the FSM returns to IDLE.

Decomposition:
- Shared package clint_pkg:
  - offset constants MSIP_OFF, MTIMECMP_OFF, MTIME_OFF;
  - typedef clint_state_t {IDLE, RESP};
  - helper function apply_byte_en(old, new, be).
- Natural sub-module: clint_mtime_counter. It holds the prescaler, the 64-bit counter, and the write-priority logic, with ports CLK, RST, wr_lo, wr_hi, wdata, byte_en, mtime.

Test Plan:
- Reset, then idle 10 cycles with PRESCALE=1 -> mtime==10; timer_int==0; soft_int==0; busy==1.
- Write mtimecmp[0] low=0x20, high=0 -> timer_int[0] rises in the cycle after mtime reaches 0x20. Then write high=1 -> timer_int[0] deasserts one cycle after the commit edge.
- Write msip[1]=0xFFFFFFFF -> soft_int[1]=1 and a read returns 0x1. Write 0 -> soft_int[1]=0. soft_int[0] is unaffected throughout.
- Write the mtime low word = 0xFFFFFFFF with byte_en=4'b0011 on a tick cycle -> low becomes 0x0000FFFF with no tick applied, then counting resumes. Set mtime = all-ones -> it wraps to 0 on the next tick.
- Read mtimecmp[5] with NUM_HARTS=2, and read offset 0x8000 -> rdata=0, busy low exactly one cycle each. Issue back-to-back reads -> completed on every second cycle.
- Assert RST in the RESP cycle of a mtimecmp write -> the register stays all-ones, FSM is IDLE, and busy==1 the next cycle.
